// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Fills instruction memory from a byte stream before the CPU starts fetching.
// Bytes arrive on a valid/ready handshake and are packed big-endian into 32-bit
// words (the first byte lands in bits 31:24). Each word is written to the next
// word-aligned address. Loading stops on the all-zero halt word, after which
// cpu_run releases the CPU. If memory fills without a halt word, load_error
// latches instead.
//
// Parameters:
//   MEM_WORDS    instruction memory depth in words (2 .. 2^30)
//   IDX_W        word index width, 2^IDX_W >= MEM_WORDS
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   in_valid     byte source has a byte on in_byte
//   in_byte      stream byte
//   in_ready     loader accepts a byte this cycle
//   imem_we      instruction memory write strobe
//   imem_a       word-aligned byte address of the write
//   imem_wd      word being written
//   words_loaded words written so far, halt word included
//   cpu_run      program loaded, CPU may fetch
//   load_error   memory filled without a halt word
//   checksum     (only with IMEM_LOADER_CHECKSUM_EN) 32-bit sum of all
//                words written, halt word included
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//
// State table:
//   state   | meaning
//   LOAD    | collecting bytes of the current word
//   WRITE   | one-cycle memory write of the assembled word
//   DONE    | halt word written, CPU released (sticky)
//   ERROR   | memory full without halt word (sticky)
// -----------------------------------------------------------------------------
module imem_program_loader #(
    parameter int MEM_WORDS = 64,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             imem_we,
    output logic [31:0]      imem_a,
    output logic [31:0]      imem_wd,
    output logic [IDX_W:0]   words_loaded,
    output logic             cpu_run,
    output logic             load_error
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_WORDS - 1);

    logic [1:0]       state;
    logic [1:0]       byte_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_LOAD;
            byte_cnt     <= 2'd0;
            word_idx     <= '0;
            word         <= 32'd0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum     <= 32'd0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        word     <= {word[23:0], in_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + (IDX_W+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum     <= checksum + word;
`endif
                    // Halt-word check wins over the full-memory check so a
                    // terminator in the last slot still completes cleanly.
                    if (word == 32'd0) begin
                        state <= S_DONE;
                    end else if (word_idx == LAST_IDX) begin
                        state <= S_ERROR;
                    end else begin
                        word_idx <= word_idx + IDX_W'(1);
                        state    <= S_LOAD;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    // Outputs decode the state register; the write commits on the edge that
    // ends WRITE because the memory samples we/a/wd on that same edge.
    assign in_ready   = (state == S_LOAD);
    assign imem_we    = (state == S_WRITE);
    assign imem_a     = imem_we ? 32'({word_idx, 2'b00}) : 32'd0;
    assign imem_wd    = imem_we ? word : 32'd0;
    assign cpu_run    = (state == S_DONE);
    assign load_error = (state == S_ERROR);

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
//
// Two loaders: dut_a with the default depth (64 words) and dut_b with a
// 4-word memory for the full-memory and last-slot cases. Stimulus pushes the
// expected (address, data) pair of every write into a per-DUT queue; a monitor
// on the falling edge pops and compares whenever imem_we is high.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, valid_a;
    logic [7:0]  byte_a;
    logic        ready_a, we_a, run_a, err_a;
    logic [31:0] a_a, wd_a;
    logic [6:0]  wl_a;

    logic        reset_b, valid_b;
    logic [7:0]  byte_b;
    logic        ready_b, we_b, run_b, err_b;
    logic [31:0] a_b, wd_b;
    logic [2:0]  wl_b;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] cks_a, cks_b;
`endif

    imem_program_loader #(.MEM_WORDS(64), .IDX_W(6)) dut_a (
        .clk(clk), .reset(reset_a), .in_valid(valid_a), .in_byte(byte_a),
        .in_ready(ready_a), .imem_we(we_a), .imem_a(a_a), .imem_wd(wd_a),
        .words_loaded(wl_a), .cpu_run(run_a), .load_error(err_a)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cks_a)
`endif
    );

    imem_program_loader #(.MEM_WORDS(4), .IDX_W(2)) dut_b (
        .clk(clk), .reset(reset_b), .in_valid(valid_b), .in_byte(byte_b),
        .in_ready(ready_b), .imem_we(we_b), .imem_a(a_b), .imem_wd(wd_b),
        .words_loaded(wl_b), .cpu_run(run_b), .load_error(err_b)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cks_b)
`endif
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    logic [63:0] e_a, e_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset_a) begin
            if (we_a) begin
                if (exp_a.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL dut_a unexpected write: a=0x%08h wd=0x%08h", a_a, wd_a);
                end else begin
                    e_a = exp_a.pop_front();
                    check("dut_a write addr", a_a, e_a[63:32]);
                    check("dut_a write data", wd_a, e_a[31:0]);
                end
            end
            if (!run_a && !err_a) check("dut_a in_ready low only on write", {31'd0, ready_a}, {31'd0, !we_a});
        end
        if (!reset_b) begin
            if (we_b) begin
                if (exp_b.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL dut_b unexpected write: a=0x%08h wd=0x%08h", a_b, wd_b);
                end else begin
                    e_b = exp_b.pop_front();
                    check("dut_b write addr", a_b, e_b[63:32]);
                    check("dut_b write data", wd_b, e_b[31:0]);
                end
            end
            if (!run_b && !err_b) check("dut_b in_ready low only on write", {31'd0, ready_b}, {31'd0, !we_b});
        end
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ready_a : ready_b;
    endfunction

    function automatic logic flag(input int sel, input bit want_err);
        if (sel == 0) return want_err ? err_a : run_a;
        return want_err ? err_b : run_b;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] b);
        if (sel == 0) begin valid_a = v; byte_a = b; end
        else begin valid_b = v; byte_b = b; end
    endtask

    // Presents a byte from a falling edge and returns right after the rising
    // edge that accepts it.
    task automatic send_byte(input int sel, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        drive(sel, 1'b1, b);
        while (!rdy(sel) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++; fails++;
            $display("FAIL send_byte timeout: sel=%0d byte=0x%02h", sel, b);
        end
        @(posedge clk);
    endtask

    task automatic send_word(input int sel, input logic [31:0] w, input logic [31:0] addr, input bit gap);
        if (sel == 0) exp_a.push_back({addr, w});
        else exp_b.push_back({addr, w});
        for (int i = 3; i >= 0; i--) begin
            send_byte(sel, w[8*i +: 8]);
            if (gap) begin
                @(negedge clk);
                drive(sel, 1'b0, 8'h00);
            end
        end
    endtask

    task automatic idle(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic do_reset(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00);
        if (sel == 0) reset_a = 1'b1; else reset_b = 1'b1;
        @(negedge clk);
        if (sel == 0) reset_a = 1'b0; else reset_b = 1'b0;
    endtask

    task automatic wait_for(input int sel, input bit want_err, input string name);
        int n = 0;
        while (!flag(sel, want_err) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++; fails++;
            $display("FAIL %s: timeout waiting for flag", name);
        end
    endtask

    int t0, t1;

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        byte_a  = 8'h00; byte_b = 8'h00;
        repeat (2) @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;

        // Reset state
        check("reset in_ready", {31'd0, ready_a}, 32'd1);
        check("reset imem_we", {31'd0, we_a}, 32'd0);
        check("reset imem_a", a_a, 32'd0);
        check("reset imem_wd", wd_a, 32'd0);
        check("reset words_loaded", {25'd0, wl_a}, 32'd0);
        check("reset cpu_run", {31'd0, run_a}, 32'd0);
        check("reset load_error", {31'd0, err_a}, 32'd0);
        check("reset b in_ready", {31'd0, ready_b}, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("reset checksum", cks_a, 32'd0);
`endif

        // Back-to-back stream, cpu_run on the 10th cycle
        exp_a.push_back({32'h0, 32'h20020005});
        exp_a.push_back({32'h4, 32'h00000000});
        send_byte(0, 8'h20);
        #1 t0 = cyc;
        send_byte(0, 8'h02);
        send_byte(0, 8'h00);
        send_byte(0, 8'h05);
        for (int i = 0; i < 4; i++) send_byte(0, 8'h00);
        idle(0);
        check("t1 write latency imem_we", {31'd0, we_a}, 32'd1);
        check("t1 cpu_run not yet", {31'd0, run_a}, 32'd0);
        wait_for(0, 1'b0, "t1 cpu_run");
        t1 = cyc;
        check("t1 cpu_run cycle", t1 - t0, 32'd9);
        check("t1 words_loaded", {25'd0, wl_a}, 32'd2);
        check("t1 load_error", {31'd0, err_a}, 32'd0);
        // DONE ignores further bytes
        @(negedge clk);
        drive(0, 1'b1, 8'h55);
        repeat (3) begin
            @(negedge clk);
            check("done in_ready", {31'd0, ready_a}, 32'd0);
        end
        idle(0);
        check("done words_loaded held", {25'd0, wl_a}, 32'd2);
        check("done cpu_run sticky", {31'd0, run_a}, 32'd1);

        // Toggling in_valid
        do_reset(0);
        check("t2 cpu_run cleared", {31'd0, run_a}, 32'd0);
        send_word(0, 32'h20020005, 32'h0, 1'b1);
        send_word(0, 32'h00000000, 32'h4, 1'b1);
        wait_for(0, 1'b0, "t2 cpu_run");
        check("t2 words_loaded", {25'd0, wl_a}, 32'd2);

        // Reset mid-word discards the partial word
        do_reset(0);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        do_reset(0);
        send_word(0, 32'h11223344, 32'h0, 1'b0);
        send_word(0, 32'h00000000, 32'h4, 1'b0);
        idle(0);
        wait_for(0, 1'b0, "t5 cpu_run");
        check("t5 words_loaded", {25'd0, wl_a}, 32'd2);

        // Checksum stream
        do_reset(0);
        send_word(0, 32'hFFFFFFFF, 32'h0, 1'b0);
        send_word(0, 32'h00000002, 32'h4, 1'b0);
        send_word(0, 32'h00000000, 32'h8, 1'b0);
        idle(0);
        wait_for(0, 1'b0, "t6 cpu_run");
        check("t6 words_loaded", {25'd0, wl_a}, 32'd3);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t6 checksum", cks_a, 32'h00000001);
`endif

        // 4-word memory filled without terminator
        send_word(1, 32'h01010101, 32'h0, 1'b0);
        send_word(1, 32'h02020202, 32'h4, 1'b0);
        send_word(1, 32'h03030303, 32'h8, 1'b0);
        send_word(1, 32'h04040404, 32'hC, 1'b0);
        idle(1);
        wait_for(1, 1'b1, "t3 load_error");
        check("t3 load_error", {31'd0, err_b}, 32'd1);
        check("t3 cpu_run", {31'd0, run_b}, 32'd0);
        check("t3 in_ready", {31'd0, ready_b}, 32'd0);
        check("t3 words_loaded", {29'd0, wl_b}, 32'd4);
        @(negedge clk);
        drive(1, 1'b1, 8'h77);
        repeat (2) @(negedge clk);
        check("t3 error sticky", {31'd0, err_b}, 32'd1);
        idle(1);

        // Terminator in the last slot
        do_reset(1);
        check("t4 load_error cleared", {31'd0, err_b}, 32'd0);
        send_word(1, 32'h0A0B0C0D, 32'h0, 1'b0);
        send_word(1, 32'h11111111, 32'h4, 1'b0);
        send_word(1, 32'h80000000, 32'h8, 1'b0);
        send_word(1, 32'h00000000, 32'hC, 1'b0);
        idle(1);
        wait_for(1, 1'b0, "t4 cpu_run");
        check("t4 cpu_run", {31'd0, run_b}, 32'd1);
        check("t4 load_error", {31'd0, err_b}, 32'd0);
        check("t4 words_loaded", {29'd0, wl_b}, 32'd4);

        repeat (3) @(negedge clk);
        check("dut_a writes outstanding", exp_a.size(), 32'd0);
        check("dut_b writes outstanding", exp_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction-memory interface: fills instruction memory with a program before the CPU fetches from it.
- Accepts a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words.
- Writes each word to consecutive word-aligned addresses.
- Stops on the all-zero halt word, which is the same word the bench uses to end simulation, then asserts cpu_run to release the CPU.

Parameters:
- MEM_WORDS, 64, instruction memory depth in words; legal range 2..2^30.
- IDX_W, 6, width of word index/counter; must satisfy 2^IDX_W >= MEM_WORDS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte source has a byte on in_byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_a  output  32  byte address, always word-aligned: {word_idx, 2'b00} zero-extended.
- imem_wd  output  32  word being written.
- words_loaded  output  IDX_W+1  count of words written, including the terminator.
- cpu_run  output  1  program loaded; CPU may fetch.
- load_error  output  1  memory filled without a terminator.

Behaviour:
- States: LOAD, WRITE, DONE, ERROR. Reset enters LOAD.
- Reset values:
  - byte_cnt=0, word_idx=0, shift register=0.
  - in_ready=1 (registered, follows state), imem_we=0, imem_a=0, imem_wd=0.
  - words_loaded=0, cpu_run=0, load_error=0.
- LOAD:
  - in_ready=1.
  - A byte is accepted on an edge where in_valid && in_ready.
  - Shift register update: word <= {word[23:0], in_byte]}, so the first byte lands in bits 31:24.
  - byte_cnt increments mod 4. When the 4th byte is accepted, go to WRITE.
  - in_valid low leaves all state unchanged; there is no timeout.
- WRITE (exactly 1 cycle):
  - in_ready=0, imem_we=1, imem_a={word_idx,2'b00}, imem_wd=assembled word.
  - The outputs are combinational from state/registers, so the write commits at the edge that ends WRITE.
  - At that edge, words_loaded increments. Then:
    - word==0: go to DONE.
    - else if word_idx==MEM_WORDS-1: go to ERROR.
    - else: word_idx+1, go to LOAD.
- DONE:
  - in_ready=0, imem_we=0, cpu_run=1.
  - Sticky until reset. Bytes offered are ignored (not accepted).
- ERROR:
  - load_error=1, cpu_run=0, in_ready=0, imem_we=0.
  - Sticky until reset.
- Throughput: 5 cycles per word minimum (4 accept + 1 write). Latency from the 4th byte to imem_we=1 is 1 cycle.
- Boundaries:
  - Terminator in the last slot (index MEM_WORDS-1): goes to DONE, not ERROR; the zero check takes priority.
  - Reset asserted mid-word: the partial word is discarded, and a half-assembled word is never written.
  - Reset asserted during WRITE: imem_we is 0 from the next cycle. The write at that edge still occurs, because the memory samples we on the same edge.
  - Memory contents are never cleared by the loader.
  - imem_a never exceeds (MEM_WORDS-1)*4.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], reset 0.
  - On every WRITE edge: checksum <= checksum + word, modulo 2^32, terminator included (it adds 0).
  - Frozen in DONE and ERROR.
- Undefined:
  - Port and logic absent.
  - All other behaviour is identical.

Test Plan:
- Stream 20 02 00 05, 00 00 00 00 with in_valid held high:
  - imem_we pulses with a=0x0, wd=0x20020005.
  - Then a=0x4, wd=0x00000000.
  - cpu_run=1 on cycle 10; words_loaded=2.
- Same stream with in_valid toggling every other cycle:
  - Identical writes and values; cpu_run is delayed only.
  - in_ready=0 exactly on the WRITE cycles.
- MEM_WORDS=4, stream four nonzero words (e.g. 0x01010101):
  - Four writes to addresses 0x0–0xC.
  - load_error=1, cpu_run=0, in_ready=0 afterwards.
- MEM_WORDS=4, three nonzero words then 00 00 00 00:
  - Terminator written at 0xC; cpu_run=1; load_error=0.
- Feed AA BB, assert reset for 1 cycle, then stream 11 22 33 44, 00 00 00 00:
  - First write is a=0x0, wd=0x11223344; no write containing AA/BB occurs.
- With IMEM_LOADER_CHECKSUM_EN, stream 0xFFFFFFFF, 0x00000002, 0x00000000:
  - checksum=0x00000001 after DONE.
